instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/im_pkg.sv | 33 +++
 rtl/inst_byte_asm.sv | 56 +++++
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// Shared definitions for the byte-wide instruction fetch unit.
// Holds the memory geometry, the instruction size and PC step, the fetch
// FSM state enumeration, and a helper that maps a fetch state to the byte
// offset (relative to pc) that it presents to the instruction memory.
package im_pkg;

   localparam int          IM_DEPTH   = 32'sd256;
   localparam int          INST_BYTES = 32'sd4;
   localparam logic [63:0] PC_STEP    = 64'd4;

   typedef enum logic [2:0] {
      F0   = 3'd0,
      F1   = 3'd1,
      F2   = 3'd2,
      F3   = 3'd3,
      HOLD = 3'd4
   } fetch_state_t;

   // HOLD presents the F0 address of the held pc, so it maps to offset 0.
   function automatic logic [1:0] byte_offset(input fetch_state_t st);
      logic [1:0] off;
      case (st)
         F0:      off = 2'd0;
         F1:      off = 2'd1;
         F2:      off = 2'd2;
         F3:      off = 2'd3;
         HOLD:    off = 2'd0;
         default: off = 2'd0;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/inst_byte_asm.sv
// Big-endian instruction assembler.
// Collects one byte per capture into a 32-bit word: byte_sel 0 lands in
// [31:24], byte_sel 3 lands in [7:0]. clear drops any partial word and has
// priority over capture.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clear         - zero the word on the next edge
//   capture       - write byte_in into the lane chosen by byte_sel
//   byte_sel      - byte index within the instruction (0 = first byte)
//   byte_in       - byte read from instruction memory
//   word          - registered assembled word
module inst_byte_asm
   import im_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      capture,
   input  logic [1:0]                byte_sel,
   input  logic [7:0]                byte_in,
   output logic [INST_BYTES*8-1:0]   word
);

   logic [INST_BYTES*8-1:0] word_r;
   logic [INST_BYTES*8-1:0] word_next_s;

   // Next-word merge: clear first, otherwise drop the byte into its lane.
   always_comb begin
      word_next_s = word_r;
      if (clear) begin
         word_next_s = '0;
      end else if (capture) begin
         case (byte_sel)
            2'd0:    word_next_s[31:24] = byte_in;
            2'd1:    word_next_s[23:16] = byte_in;
            2'd2:    word_next_s[15:8]  = byte_in;
            2'd3:    word_next_s[7:0]   = byte_in;
            default: word_next_s        = word_r;
         endcase
      end else begin
         word_next_s = word_r;
      end
   end

   // Word register.
   always_ff @(posedge clock) begin
      if (reset) begin
         word_r <= '0;
      end else begin
         word_r <= word_next_s;
      end
   end

   assign word = word_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit for a byte-wide instruction memory.
// Reads four consecutive bytes (states F0..F3), then presents the assembled
// big-endian instruction in HOLD until the consumer accepts it. A redirect
// (branch_valid) restarts fetch at the word-aligned target from any state
// and flags a misaligned target for one cycle.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   im_addr        - registered byte address to instruction memory
//   im_rdata       - combinational byte read at im_addr
//   branch_valid   - redirect request (one-cycle pulse)
//   branch_target  - redirect byte address
//   inst_valid     - inst/inst_pc hold a complete instruction
//   inst_ready     - consumer accepts the instruction (used only in HOLD)
//   inst           - assembled instruction, first byte in [31:24]
//   inst_pc        - address of the instruction's first byte
//   misalign_err   - one-cycle pulse after a redirect with target[1:0] != 0
module instr_fetch
   import im_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          IM_AW    = 8
)
(
   input  logic              clock,
   input  logic              reset,
   output logic [IM_AW-1:0]  im_addr,
   input  logic [7:0]        im_rdata,
   input  logic              branch_valid,
   input  logic [63:0]       branch_target,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [63:0]       inst_pc,
   output logic              misalign_err
);

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic [63:0]       pc_r;
   logic [63:0]       pc_next_s;
   logic [IM_AW-1:0]  addr_r;
   logic [IM_AW-1:0]  addr_next_s;
   logic              valid_r;
   logic              valid_next_s;
   logic [63:0]       inst_pc_r;
   logic [63:0]       inst_pc_next_s;
   logic              mis_r;
   logic              mis_next_s;
   logic              capture_s;
   logic              clear_s;
   logic [1:0]        sel_s;

   // Next-state, pc and handshake logic; a redirect overrides everything.
   always_comb begin
      state_next_s   = state_r;
      pc_next_s      = pc_r;
      valid_next_s   = valid_r;
      inst_pc_next_s = inst_pc_r;
      mis_next_s     = 1'b0;
      capture_s      = 1'b0;
      clear_s        = 1'b0;

      case (state_r)
         F0: begin
            capture_s    = 1'b1;
            state_next_s = F1;
         end
         F1: begin
            capture_s    = 1'b1;
            state_next_s = F2;
         end
         F2: begin
            capture_s    = 1'b1;
            state_next_s = F3;
         end
         F3: begin
            capture_s      = 1'b1;
            state_next_s   = HOLD;
            valid_next_s   = 1'b1;
            inst_pc_next_s = pc_r;
         end
         HOLD: begin
            if (inst_ready) begin
               pc_next_s    = pc_r + PC_STEP;
               state_next_s = F0;
               valid_next_s = 1'b0;
               clear_s      = 1'b1;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s = F0;
            valid_next_s = 1'b0;
            clear_s      = 1'b1;
         end
      endcase

      // A handshake in the same cycle still consumes the instruction; only
      // the pc choice changes, so the redirect is applied on top of it.
      if (branch_valid) begin
         pc_next_s    = {branch_target[63:2], 2'b00};
         state_next_s = F0;
         valid_next_s = 1'b0;
         capture_s    = 1'b0;
         clear_s      = 1'b1;
         mis_next_s   = |branch_target[1:0];
      end else begin
         mis_next_s   = 1'b0;
      end
   end

   // Byte lane for the current fetch state.
   always_comb begin
      sel_s = byte_offset(state_r);
   end

   // Memory address is precomputed for the state being entered so the
   // im_addr output comes straight from a flop.
   always_comb begin
      addr_next_s = pc_next_s[IM_AW-1:0] + IM_AW'(byte_offset(state_next_s));
   end

   // Control and output registers; reset beats redirect and handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= F0;
         pc_r      <= RESET_PC;
         addr_r    <= RESET_PC[IM_AW-1:0];
         valid_r   <= 1'b0;
         inst_pc_r <= 64'h0;
         mis_r     <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         pc_r      <= pc_next_s;
         addr_r    <= addr_next_s;
         valid_r   <= valid_next_s;
         inst_pc_r <= inst_pc_next_s;
         mis_r     <= mis_next_s;
      end
   end

   inst_byte_asm u_asm (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear_s),
      .capture  (capture_s),
      .byte_sel (sel_s),
      .byte_in  (im_rdata),
      .word     (inst)
   );

   assign im_addr      = addr_r;
   assign inst_valid   = valid_r;
   assign inst_pc      = inst_pc_r;
   assign misalign_err = mis_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A transaction-level reference model
// tracks the pc and how many bytes of the current instruction have been
// read (0..4, 4 = presenting); expected outputs come from that model and a
// bench-side copy of the instruction memory.
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  im_addr;
   logic [7:0]  im_rdata;
   logic        branch_valid;
   logic [63:0] branch_target;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        misalign_err;

   logic [7:0]  mem [0:255];

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [63:0] m_pc;
   int          m_cnt;
   logic        m_valid;
   logic        m_mis;
   logic [31:0] m_inst;
   logic [63:0] m_inst_pc;

   instr_fetch #(.RESET_PC(64'h0), .IM_AW(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .im_addr       (im_addr),
      .im_rdata      (im_rdata),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .misalign_err  (misalign_err)
   );

   assign im_rdata = mem[im_addr];

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge given the inputs at that edge.
   task automatic model_step(input logic r, input logic rdy, input logic br, input logic [63:0] tgt);
      logic [7:0] a;
      if (r) begin
         m_pc = 64'h0; m_cnt = 0; m_valid = 1'b0; m_mis = 1'b0;
         m_inst = 32'h0; m_inst_pc = 64'h0;
      end else if (br) begin
         m_pc = tgt & ~64'h3; m_cnt = 0; m_valid = 1'b0; m_mis = (tgt[1:0] != 2'b00);
      end else begin
         m_mis = 1'b0;
         if (m_cnt < 4) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 4) begin
               m_valid = 1'b1;
               m_inst_pc = m_pc;
               a = m_pc[7:0];
               m_inst = {mem[a], mem[8'(a + 8'd1)], mem[8'(a + 8'd2)], mem[8'(a + 8'd3)]};
            end
         end else if (rdy) begin
            m_pc = m_pc + 64'd4; m_cnt = 0; m_valid = 1'b0;
         end
      end
   endtask

   task automatic check_model();
      logic [7:0] ea;
      ea = m_pc[7:0] + ((m_cnt < 4) ? 8'(m_cnt) : 8'd0);
      chk("im_addr", {56'h0, im_addr}, {56'h0, ea});
      chk("inst_valid", {63'h0, inst_valid}, {63'h0, m_valid});
      chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_mis});
      if (m_valid) begin
         chk("inst", {32'h0, inst}, {32'h0, m_inst});
         chk("inst_pc", inst_pc, m_inst_pc);
      end
   endtask

   task automatic tick(input logic r, input logic rdy, input logic br, input logic [63:0] tgt);
      reset = r; inst_ready = rdy; branch_valid = br; branch_target = tgt;
      @(posedge clock);
      model_step(r, rdy, br, tgt);
      #1;
      check_model();
      branch_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; inst_ready = 1'b0; branch_valid = 1'b0; branch_target = 64'h0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      // basic fetch of 12 34 56 78 with ready held high
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      tick(1'b1, 1'b1, 1'b0, 64'h0);
      tick(1'b1, 1'b1, 1'b0, 64'h0);
      chk("rst_inst", {32'h0, inst}, 64'h0);
      chk("rst_inst_pc", inst_pc, 64'h0);
      chk("rst_addr", {56'h0, im_addr}, 64'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0, 64'h0);
      chk("basic_inst", {32'h0, inst}, 64'h12345678);
      chk("basic_pc", inst_pc, 64'h0);
      chk("basic_valid", {63'h0, inst_valid}, 64'h1);
      tick(1'b0, 1'b1, 1'b0, 64'h0);
      chk("basic_next_addr", {56'h0, im_addr}, 64'h4);

      // stall in HOLD for 3 cycles
      tick(1'b1, 1'b0, 1'b0, 64'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, 1'b0, 64'h0);
         chk("stall_inst", {32'h0, inst}, 64'h12345678);
         chk("stall_pc", inst_pc, 64'h0);
         chk("stall_addr", {56'h0, im_addr}, 64'h0);
      end
      tick(1'b0, 1'b1, 1'b0, 64'h0);
      chk("stall_release_addr", {56'h0, im_addr}, 64'h4);

      // redirect during F2 to aligned 40
      for (int i = 40; i < 44; i++) mem[i] = 8'h55;
      tick(1'b1, 1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 1'b1, 64'd40);
      chk("br40_mis", {63'h0, misalign_err}, 64'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 64'h0);
      chk("br40_inst", {32'h0, inst}, 64'h55555555);
      chk("br40_pc", inst_pc, 64'd40);

      // misaligned redirect to 82 from HOLD
      for (int i = 80; i < 84; i++) mem[i] = 8'hAA;
      tick(1'b0, 1'b0, 1'b1, 64'd82);
      chk("br82_mis", {63'h0, misalign_err}, 64'h1);
      chk("br82_addr", {56'h0, im_addr}, 64'd80);
      tick(1'b0, 1'b0, 1'b0, 64'h0);
      chk("br82_mis_clr", {63'h0, misalign_err}, 64'h0);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 64'h0);
      chk("br82_inst", {32'h0, inst}, 64'hAAAAAAAA);
      chk("br82_pc", inst_pc, 64'd80);

      // address-space wrap at 0xFC
      mem[252] = 8'h01; mem[253] = 8'h02; mem[254] = 8'h03; mem[255] = 8'h04;
      tick(1'b0, 1'b0, 1'b1, 64'hFC);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 64'h0);
      chk("wrap_inst", {32'h0, inst}, 64'h01020304);
      tick(1'b0, 1'b1, 1'b0, 64'h0);
      chk("wrap_addr", {56'h0, im_addr}, 64'h0);
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 64'h0);
      chk("wrap_pc", inst_pc, 64'h100);

      // reset wins over a redirect mid-fetch
      tick(1'b1, 1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 1'b0, 64'h0);
      tick(1'b1, 1'b1, 1'b1, 64'h83);
      chk("rstbr_valid", {63'h0, inst_valid}, 64'h0);
      chk("rstbr_mis", {63'h0, misalign_err}, 64'h0);
      chk("rstbr_addr", {56'h0, im_addr}, 64'h0);
      tick(1'b0, 1'b0, 1'b0, 64'h0);

      // randomized traffic against the model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      tick(1'b1, 1'b0, 1'b0, 64'h0);
      for (int n = 0; n < 600; n++) begin
         tick(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 7) == 0),
              {32'($urandom), 32'($urandom)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
